mac_vec: RTL and testbench

- Parametrised, pipelined, multi-lane signed multiply-accumulate engine; successor to the single-lane 8x8/26-bit mac.
- Each accepted beat carries LANES operand pairs; their products are summed and accumulated into a running dot product.
- A beat flagged `last` closes the dot product, which is delivered through a valid/ready output register with a beat count and an overflow flag.
- Sits between the operand stream source and the result consumer in the datapath.

---
 rtl/mac_vec.sv | 156 +++++++++++++++
 tb/tb_mac_vec.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_vec.sv
// ============================================================================
// mac_vec : pipelined multi-lane signed multiply-accumulate (dot product)
// Optional macro MAC_SAT_EN: saturating accumulator instead of wrapping.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_vec #(
  parameter int A_W   = 8,
  parameter int B_W   = 8,
  parameter int LANES = 4,
  parameter int ACC_W = 26,
  parameter int LEN_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   in_vld,
  output logic                   in_rdy,
  input  logic [LANES*A_W-1:0]   a,
  input  logic [LANES*B_W-1:0]   b,
  input  logic                   last,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [ACC_W-1:0]       out_acc,
  output logic [LEN_W-1:0]       out_cnt,
  output logic                   out_ovf
);

  localparam int c_prod_w = A_W + B_W;
  localparam logic [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [LEN_W-1:0] c_cnt_max = {LEN_W{1'b1}};

  logic                      w_stall;
  logic                      w_accept;
  logic                      w_adv;
  logic                      w_write;
  logic signed [ACC_W-1:0]   w_sum;
  logic signed [c_prod_w-1:0] w_pa;
  logic signed [c_prod_w-1:0] w_pb;
  logic signed [ACC_W-1:0]   w_base;
  logic signed [ACC_W-1:0]   w_add;
  logic signed [ACC_W-1:0]   w_acc_nxt;
  logic                      w_o;
  logic [LEN_W-1:0]          w_cnt_nxt;
  logic                      w_ovf_nxt;

  logic                      r_s1_vld;
  logic                      r_s1_last;
  logic signed [ACC_W-1:0]   r_s1_sum;
  logic signed [ACC_W-1:0]   r_acc;
  logic [LEN_W-1:0]          r_cnt;
  logic                      r_ovf;
  logic                      r_fresh;
  logic                      r_out_vld;
  logic [ACC_W-1:0]          r_out_acc;
  logic [LEN_W-1:0]          r_out_cnt;
  logic                      r_out_ovf;

  assign w_stall  = r_out_vld & ~out_rdy;
  assign in_rdy   = ~w_stall;
  // A beat presented during clr is dropped even though in_rdy may be high.
  assign w_accept = in_vld & ~w_stall & ~clr;
  assign w_adv    = r_s1_vld & ~w_stall & ~clr;
  assign w_write  = w_adv & r_s1_last;

  // Lane products sign-extended to ACC_W and summed.
  always_comb begin
    w_sum = '0;
    w_pa  = '0;
    w_pb  = '0;
    for (int i = 0; i < LANES; i++) begin
      w_pa  = c_prod_w'($signed(a[i*A_W +: A_W]));
      w_pb  = c_prod_w'($signed(b[i*B_W +: B_W]));
      w_sum = w_sum + ACC_W'(w_pa * w_pb);
    end
  end

  always_comb begin
    w_base = r_fresh ? '0 : r_acc;
    w_add  = w_base + r_s1_sum;
    w_o    = (w_base[ACC_W-1] == r_s1_sum[ACC_W-1]) &&
             (w_add[ACC_W-1] != w_base[ACC_W-1]);
`ifdef MAC_SAT_EN
    if (w_o) w_acc_nxt = w_base[ACC_W-1] ? c_acc_min : c_acc_max;
    else     w_acc_nxt = w_add;
`else
    w_acc_nxt = w_add;
`endif
    if (r_fresh)                 w_cnt_nxt = LEN_W'(1);
    else if (r_cnt == c_cnt_max) w_cnt_nxt = r_cnt;
    else                         w_cnt_nxt = r_cnt + LEN_W'(1);
    w_ovf_nxt = (~r_fresh & r_ovf) | w_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_sum  <= '0;
    end else if (clr) begin
      r_s1_vld  <= 1'b0;
    end else if (!w_stall) begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_last <= last;
        r_s1_sum  <= w_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_fresh <= 1'b1;
    end else if (clr) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_fresh <= 1'b1;
    end else if (w_adv) begin
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
      r_fresh <= r_s1_last;
    end
  end

  // A new result overrides a same-edge handshake so out_vld stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld <= 1'b0;
      r_out_acc <= '0;
      r_out_cnt <= '0;
      r_out_ovf <= 1'b0;
    end else if (w_write) begin
      r_out_vld <= 1'b1;
      r_out_acc <= w_acc_nxt;
      r_out_cnt <= w_cnt_nxt;
      r_out_ovf <= w_ovf_nxt;
    end else if (out_rdy) begin
      r_out_vld <= 1'b0;
    end
  end

  assign out_vld = r_out_vld;
  assign out_acc = r_out_acc;
  assign out_cnt = r_out_cnt;
  assign out_ovf = r_out_ovf;

endmodule

`default_nettype wire

// File: tb/tb_mac_vec.sv
// ============================================================================
// tb_mac_vec : directed self-checking bench for mac_vec (three configurations)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_vec;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic in_vld = 1'b0;
  logic last = 1'b0;
  logic out_rdy = 1'b1;

  // default configuration
  logic [31:0]        a4 = '0, b4 = '0;
  logic               rdy4, vld4, ovf4;
  logic signed [25:0] acc4;
  logic [9:0]         cnt4;
  // LANES=1
  logic [7:0]         a1 = '0, b1 = '0;
  logic               rdy1, vld1, ovf1;
  logic signed [25:0] acc1;
  logic [9:0]         cnt1;
  // ACC_W=18
  logic [31:0]        aw = '0, bw = '0;
  logic               rdyw, vldw, ovfw;
  logic signed [17:0] accw;
  logic [9:0]         cntw;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mac_vec u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_vld(in_vld), .in_rdy(rdy4),
    .a(a4), .b(b4), .last(last), .out_vld(vld4), .out_rdy(out_rdy),
    .out_acc(acc4), .out_cnt(cnt4), .out_ovf(ovf4)
  );

  mac_vec #(.LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_vld(in_vld), .in_rdy(rdy1),
    .a(a1), .b(b1), .last(last), .out_vld(vld1), .out_rdy(out_rdy),
    .out_acc(acc1), .out_cnt(cnt1), .out_ovf(ovf1)
  );

  mac_vec #(.ACC_W(18)) u_w18 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_vld(in_vld), .in_rdy(rdyw),
    .a(aw), .b(bw), .last(last), .out_vld(vldw), .out_rdy(out_rdy),
    .out_acc(accw), .out_cnt(cntw), .out_ovf(ovfw)
  );

  // Timing convention: every task starts and ends 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat_done();
    step();
    in_vld = 1'b0;
    last   = 1'b0;
  endtask

  task automatic do_reset();
    in_vld = 1'b0; last = 1'b0; clr = 1'b0; out_rdy = 1'b1;
    a4 = '0; b4 = '0; a1 = '0; b1 = '0; aw = '0; bw = '0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (vld4 !== 1'b0) begin bad++; $display("FAIL reset_vld got=%0b exp=0", vld4); end
    total++; if (rdy4 !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%0b exp=1", rdy4); end
    total++; if (acc4 !== 26'sd0) begin bad++; $display("FAIL reset_acc got=%0d exp=0", acc4); end
    total++; if (cnt4 !== 10'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt4); end
    total++; if (ovf4 !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b exp=0", ovf4); end
  endtask

  task automatic test_lanes1();
    do_reset();
    in_vld = 1'b1; a1 = 8'sd2;  b1 = 8'sd5;  step();
    a1 = 8'sd2;  b1 = -8'sd5; step();
    a1 = -8'sd3; b1 = 8'sd8;  last = 1'b1; beat_done();
    total++; if (vld1 !== 1'b0) begin bad++; $display("FAIL l1_latency_early got=%0b exp=0", vld1); end
    step();
    total++; if (vld1 !== 1'b1) begin bad++; $display("FAIL l1_vld got=%0b exp=1", vld1); end
    total++; if (acc1 !== -26'sd24) begin bad++; $display("FAIL l1_acc got=%0d exp=-24", acc1); end
    total++; if (cnt1 !== 10'd3) begin bad++; $display("FAIL l1_cnt got=%0d exp=3", cnt1); end
    total++; if (ovf1 !== 1'b0) begin bad++; $display("FAIL l1_ovf got=%0b exp=0", ovf1); end
    step();
    total++; if (vld1 !== 1'b0) begin bad++; $display("FAIL l1_vld_clear got=%0b exp=0", vld1); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_vld = 1'b1; last = 1'b1;
    a4 = {8'd4, 8'd3, 8'd2, 8'd1}; b4 = {8'd8, 8'd7, 8'd6, 8'd5}; step();
    a4 = {4{8'hFF}}; b4 = {4{8'd1}}; beat_done();
    total++; if (vld4 !== 1'b1) begin bad++; $display("FAIL b2b_vld1 got=%0b exp=1", vld4); end
    total++; if (acc4 !== 26'sd70) begin bad++; $display("FAIL b2b_acc1 got=%0d exp=70", acc4); end
    total++; if (cnt4 !== 10'd1) begin bad++; $display("FAIL b2b_cnt1 got=%0d exp=1", cnt4); end
    step();
    total++; if (vld4 !== 1'b1) begin bad++; $display("FAIL b2b_vld2 got=%0b exp=1", vld4); end
    total++; if (acc4 !== -26'sd4) begin bad++; $display("FAIL b2b_acc2 got=%0d exp=-4", acc4); end
    total++; if (cnt4 !== 10'd1) begin bad++; $display("FAIL b2b_cnt2 got=%0d exp=1", cnt4); end
    total++; if (ovf4 !== 1'b0) begin bad++; $display("FAIL b2b_ovf2 got=%0b exp=0", ovf4); end
  endtask

  task automatic test_overflow();
    logic signed [17:0] exp_acc;
`ifdef MAC_SAT_EN
    exp_acc = 18'sd131071;
`else
    exp_acc = -18'sd68596;
`endif
    do_reset();
    in_vld = 1'b1; aw = {4{8'd127}}; bw = {4{8'd127}};
    step();
    step();
    last = 1'b1; beat_done();
    step();
    total++; if (vldw !== 1'b1) begin bad++; $display("FAIL ovf_vld got=%0b exp=1", vldw); end
    total++; if (ovfw !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b exp=1", ovfw); end
    total++; if (accw !== exp_acc) begin bad++; $display("FAIL ovf_acc got=%0d exp=%0d", accw, exp_acc); end
    total++; if (cntw !== 10'd3) begin bad++; $display("FAIL ovf_cnt got=%0d exp=3", cntw); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_rdy = 1'b0;
    in_vld = 1'b1; last = 1'b1;
    a4 = {24'd0, 8'd10}; b4 = {24'd0, 8'd1}; step();
    a4 = {24'd0, 8'd20}; beat_done();
    total++; if (vld4 !== 1'b1) begin bad++; $display("FAIL bp_vld got=%0b exp=1", vld4); end
    total++; if (rdy4 !== 1'b0) begin bad++; $display("FAIL bp_in_rdy got=%0b exp=0", rdy4); end
    step(); step(); step();
    total++; if (acc4 !== 26'sd10) begin bad++; $display("FAIL bp_hold_acc got=%0d exp=10", acc4); end
    total++; if (vld4 !== 1'b1) begin bad++; $display("FAIL bp_hold_vld got=%0b exp=1", vld4); end
    out_rdy = 1'b1;
    step();
    total++; if (vld4 !== 1'b1) begin bad++; $display("FAIL bp_second_vld got=%0b exp=1", vld4); end
    total++; if (acc4 !== 26'sd20) begin bad++; $display("FAIL bp_second_acc got=%0d exp=20", acc4); end
    total++; if (cnt4 !== 10'd1) begin bad++; $display("FAIL bp_second_cnt got=%0d exp=1", cnt4); end
    step();
    total++; if (vld4 !== 1'b0) begin bad++; $display("FAIL bp_drain got=%0b exp=0", vld4); end
  endtask

  task automatic test_clr();
    do_reset();
    in_vld = 1'b1;
    a4 = {24'd0, 8'd25}; b4 = {24'd0, 8'd1}; step();
    step();
    clr = 1'b1; last = 1'b1; a4 = {24'd0, 8'd99}; step();
    clr = 1'b0; a4 = {24'd0, 8'd7}; beat_done();
    total++; if (vld4 !== 1'b0) begin bad++; $display("FAIL clr_dropped got=%0b exp=0", vld4); end
    step();
    total++; if (vld4 !== 1'b1) begin bad++; $display("FAIL clr_vld got=%0b exp=1", vld4); end
    total++; if (acc4 !== 26'sd7) begin bad++; $display("FAIL clr_acc got=%0d exp=7", acc4); end
    total++; if (cnt4 !== 10'd1) begin bad++; $display("FAIL clr_cnt got=%0d exp=1", cnt4); end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_rdy = 1'b0;
    in_vld = 1'b1; b4 = {24'd0, 8'd1};
    a4 = {24'd0, 8'd10}; last = 1'b1; step();
    a4 = {24'd0, 8'd5};  last = 1'b0; beat_done();
    step();
    total++; if (acc4 !== 26'sd10) begin bad++; $display("FAIL ar_pre_acc got=%0d exp=10", acc4); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (vld4 !== 1'b0) begin bad++; $display("FAIL ar_vld got=%0b exp=0", vld4); end
    total++; if (acc4 !== 26'sd0) begin bad++; $display("FAIL ar_acc got=%0d exp=0", acc4); end
    total++; if (cnt4 !== 10'd0) begin bad++; $display("FAIL ar_cnt got=%0d exp=0", cnt4); end
    step();
    rst_n = 1'b1; out_rdy = 1'b1;
    step();
    in_vld = 1'b1; last = 1'b1; a4 = {24'd0, 8'd3}; beat_done();
    step();
    total++; if (vld4 !== 1'b1) begin bad++; $display("FAIL ar_next_vld got=%0b exp=1", vld4); end
    total++; if (acc4 !== 26'sd3) begin bad++; $display("FAIL ar_next_acc got=%0d exp=3", acc4); end
    total++; if (cnt4 !== 10'd1) begin bad++; $display("FAIL ar_next_cnt got=%0d exp=1", cnt4); end
  endtask

  initial begin
    test_reset();
    test_lanes1();
    test_back_to_back();
    test_overflow();
    test_backpressure();
    test_clr();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
